// File: rtl/mips_dmem_ctrl.sv
// mips_dmem_ctrl
//   Data-memory controller that sits between the CPU data port and an external
//   variable-latency bus with a req/ack handshake. Stores are absorbed into a
//   FIFO write buffer so they do not stall the CPU. Loads wait until the buffer
//   has fully drained, which keeps reads ordered after earlier writes. Load
//   data is registered and held for the CPU's M stage.
//
// Ports
//   clk                 clock
//   rst                 asynchronous active-low reset
//   en_in               system run enable
//   cpu_en              pipeline enable to the CPU (en_in & ~stall)
//   cpu_mem_read_en     load request (EX stage)
//   cpu_mem_write_en    byte-lane store enables, [3] is the MSB lane
//   cpu_mem_addr        request address
//   cpu_mem_write_data  store data, lanes already replicated
//   cpu_mem_read_data   registered load data for the M stage
//   ext_req             bus request
//   ext_we              bus byte enables, 0 means read
//   ext_addr            bus address
//   ext_wdata           bus write data
//   ext_ack             one-cycle completion strobe
//   ext_rdata           bus read data, valid with ext_ack
//   wb_count            write-buffer occupancy
module mips_dmem_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_in,
  output logic                      cpu_en,
  input  logic                      cpu_mem_read_en,
  input  logic [3:0]                cpu_mem_write_en,
  input  logic [ADDR_W-1:0]         cpu_mem_addr,
  input  logic [31:0]               cpu_mem_write_data,
  output logic [31:0]               cpu_mem_read_data,
  output logic                      ext_req,
  output logic [3:0]                ext_we,
  output logic [ADDR_W-1:0]         ext_addr,
  output logic [31:0]               ext_wdata,
  input  logic                      ext_ack,
  input  logic [31:0]               ext_rdata,
  output logic [$clog2(WB_DEPTH):0] wb_count
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    RD     = 2'd2,
    RDONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ext_req_q, ext_req_d;
  logic [3:0]          ext_we_q, ext_we_d;
  logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;
  logic [31:0]         ext_wdata_q, ext_wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  // Buffer storage: data only, never reset.
  logic [ADDR_W-1:0]   wb_addr_q  [WB_DEPTH];
  logic [3:0]          wb_we_q    [WB_DEPTH];
  logic [31:0]         wb_wdata_q [WB_DEPTH];

  logic                any_we;
  logic                full;
  logic                push;
  logic                ack_v;
  logic                pop;
  logic                stall;
  logic                more_after_pop;
  logic [PTR_W-1:0]    nxt_idx;

  always_comb begin
    any_we = |cpu_mem_write_en;
    // Fullness is judged on the registered count, so a pop in the same cycle
    // does not open a slot for this cycle's push.
    full   = (count_q == DEPTH_C);
    push   = en_in & any_we & ~full;
    // An ack with no outstanding request is ignored.
    ack_v  = ext_ack & ext_req_q;
    pop    = (state_q == WDRAIN) & ack_v;
    stall  = (any_we & full) | (cpu_mem_read_en & (state_q != RDONE));
    // Entries left after this cycle's pop, including one pushed right now.
    more_after_pop = (count_q > CNT_ONE) | push;
    nxt_idx        = rd_ptr_q + PTR_ONE;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  end

  always_comb begin
    state_d     = state_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = WDRAIN;
          ext_req_d   = 1'b1;
          ext_we_d    = wb_we_q[rd_ptr_q];
          ext_addr_d  = wb_addr_q[rd_ptr_q];
          ext_wdata_d = wb_wdata_q[rd_ptr_q];
        end else if (cpu_mem_read_en && en_in) begin
          state_d    = RD;
          ext_req_d  = 1'b1;
          ext_we_d   = 4'h0;
          ext_addr_d = cpu_mem_addr;
        end
      end

      WDRAIN: begin
        if (ack_v) begin
          if (more_after_pop) begin
            // Back-to-back drain. When only the popped entry was stored, the
            // next head is the one being pushed this very cycle, so take it
            // straight from the CPU port.
            ext_req_d = 1'b1;
            if (count_q > CNT_ONE) begin
              ext_we_d    = wb_we_q[nxt_idx];
              ext_addr_d  = wb_addr_q[nxt_idx];
              ext_wdata_d = wb_wdata_q[nxt_idx];
            end else begin
              ext_we_d    = cpu_mem_write_en;
              ext_addr_d  = cpu_mem_addr;
              ext_wdata_d = cpu_mem_write_data;
            end
          end else if (cpu_mem_read_en && en_in) begin
            state_d    = RD;
            ext_req_d  = 1'b1;
            ext_we_d   = 4'h0;
            ext_addr_d = cpu_mem_addr;
          end else begin
            state_d   = IDLE;
            ext_req_d = 1'b0;
            ext_we_d  = 4'h0;
          end
        end
      end

      RD: begin
        if (ack_v) begin
          state_d   = RDONE;
          ext_req_d = 1'b0;
          rdata_d   = ext_rdata;
        end
      end

      RDONE: begin
        // One stall-free cycle lets the CPU advance past the held load.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        ext_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 4'h0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q]  <= cpu_mem_addr;
      wb_we_q[wr_ptr_q]    <= cpu_mem_write_en;
      wb_wdata_q[wr_ptr_q] <= cpu_mem_write_data;
    end
  end

  assign cpu_en            = en_in & ~stall;
  assign cpu_mem_read_data = rdata_q;
  assign ext_req           = ext_req_q;
  assign ext_we            = ext_we_q;
  assign ext_addr          = ext_addr_q;
  assign ext_wdata         = ext_wdata_q;
  assign wb_count          = count_q;

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
module tb_mips_dmem_ctrl;

  localparam int WB_DEPTH = 4;
  localparam int ADDR_W   = 32;

  logic                      clk;
  logic                      rst;
  logic                      en_in;
  logic                      cpu_en;
  logic                      cpu_mem_read_en;
  logic [3:0]                cpu_mem_write_en;
  logic [ADDR_W-1:0]         cpu_mem_addr;
  logic [31:0]               cpu_mem_write_data;
  logic [31:0]               cpu_mem_read_data;
  logic                      ext_req;
  logic [3:0]                ext_we;
  logic [ADDR_W-1:0]         ext_addr;
  logic [31:0]               ext_wdata;
  logic                      ext_ack;
  logic [31:0]               ext_rdata;
  logic [$clog2(WB_DEPTH):0] wb_count;

  int n_chk;
  int n_pass;

  mips_dmem_ctrl #(
    .WB_DEPTH(WB_DEPTH),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .en_in             (en_in),
    .cpu_en            (cpu_en),
    .cpu_mem_read_en   (cpu_mem_read_en),
    .cpu_mem_write_en  (cpu_mem_write_en),
    .cpu_mem_addr      (cpu_mem_addr),
    .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read_data (cpu_mem_read_data),
    .ext_req           (ext_req),
    .ext_we            (ext_we),
    .ext_addr          (ext_addr),
    .ext_wdata         (ext_wdata),
    .ext_ack           (ext_ack),
    .ext_rdata         (ext_rdata),
    .wb_count          (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    cpu_mem_addr       = a;
    cpu_mem_write_en   = we;
    cpu_mem_write_data = d;
  endtask

  task automatic idle_cpu();
    cpu_mem_write_en = 4'h0;
    cpu_mem_read_en  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    en_in = 1'b1;
    cpu_mem_read_en = 1'b0;
    cpu_mem_write_en = 4'h0;
    cpu_mem_addr = '0;
    cpu_mem_write_data = '0;
    ext_ack = 1'b0;
    ext_rdata = '0;

    // Reset state
    #12;
    chk("rst_req",   32'(ext_req), 32'd0);
    chk("rst_we",    32'(ext_we), 32'd0);
    chk("rst_addr",  ext_addr, 32'd0);
    chk("rst_wdata", ext_wdata, 32'd0);
    chk("rst_rdata", cpu_mem_read_data, 32'd0);
    chk("rst_cnt",   32'(wb_count), 32'd0);
    chk("rst_cpuen", 32'(cpu_en), 32'd1);
    #5 rst = 1'b1;
    tick();

    // Single word store, ack on third request cycle
    store(32'h100, 4'hF, 32'hDEADBEEF);
    #1 chk("t1_cpuen", 32'(cpu_en), 32'd1);
    tick();
    idle_cpu();
    #1 chk("t1_cnt1", 32'(wb_count), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t1_req",   32'(ext_req), 32'd1);
      chk("t1_we",    32'(ext_we), 32'hF);
      chk("t1_addr",  ext_addr, 32'h100);
      chk("t1_wdata", ext_wdata, 32'hDEADBEEF);
      chk("t1_cnt_hold", 32'(wb_count), 32'd1);
      if (i == 2) ext_ack = 1'b1;
      tick();
    end
    ext_ack = 1'b0;
    #1 chk("t1_cnt0", 32'(wb_count), 32'd0);
    chk("t1_req_drop", 32'(ext_req), 32'd0);

    // Two stores then a load; each ack one cycle late
    tick();
    store(32'h10, 4'hF, 32'h11111111);
    tick();
    store(32'h14, 4'hF, 32'h22222222);
    tick();
    idle_cpu();
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h10;
    #1 chk("t2_stall0", 32'(cpu_en), 32'd0);
    chk("t2_head0", ext_addr, 32'h10);
    chk("t2_cnt2", 32'(wb_count), 32'd2);
    tick();
    ext_ack = 1'b1;
    #1 chk("t2_stall1", 32'(cpu_en), 32'd0);
    tick();
    ext_ack = 1'b0;
    #1 chk("t2_head1", ext_addr, 32'h14);
    chk("t2_req1", 32'(ext_req), 32'd1);
    chk("t2_cnt1", 32'(wb_count), 32'd1);
    chk("t2_stall2", 32'(cpu_en), 32'd0);
    tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    #1 chk("t2_rd_req", 32'(ext_req), 32'd1);
    chk("t2_rd_we", 32'(ext_we), 32'd0);
    chk("t2_rd_addr", ext_addr, 32'h10);
    chk("t2_rd_cnt", 32'(wb_count), 32'd0);
    chk("t2_stall3", 32'(cpu_en), 32'd0);
    tick();
    ext_ack = 1'b1;
    ext_rdata = 32'hCAFEF00D;
    tick();
    ext_ack = 1'b0;
    ext_rdata = 32'h0;
    #1 chk("t2_rdone_en", 32'(cpu_en), 32'd1);
    chk("t2_rdata", cpu_mem_read_data, 32'hCAFEF00D);
    chk("t2_req_off", 32'(ext_req), 32'd0);
    tick();
    #1 chk("t2_one_cycle", 32'(cpu_en), 32'd0);
    cpu_mem_read_en = 1'b0;
    #1 chk("t2_rdata_hold", cpu_mem_read_data, 32'hCAFEF00D);

    // Buffer full with ack held low
    tick();
    for (int i = 0; i < 4; i++) begin
      store(32'h300 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
      #1 chk("t3_no_stall", 32'(cpu_en), 32'd1);
      tick();
    end
    store(32'h310, 4'hF, 32'hA0000004);
    #1 chk("t3_full_stall", 32'(cpu_en), 32'd0);
    chk("t3_cnt4", 32'(wb_count), 32'd4);
    tick();
    chk("t3_cnt4_hold", 32'(wb_count), 32'd4);
    ext_ack = 1'b1;
    #1 chk("t3_stall_ack", 32'(cpu_en), 32'd0);
    tick();
    ext_ack = 1'b0;
    #1 chk("t3_freed_en", 32'(cpu_en), 32'd1);
    chk("t3_cnt3", 32'(wb_count), 32'd3);
    chk("t3_head", ext_addr, 32'h304);
    tick();
    idle_cpu();
    #1 chk("t3_cnt_refill", 32'(wb_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_addr", ext_addr, 32'h304 + 32'(4 * k));
      chk("t3_drain_data", ext_wdata, 32'hA0000001 + 32'(k));
      ext_ack = 1'b1;
      tick();
      ext_ack = 1'b0;
      #1;
    end
    chk("t3_empty", 32'(wb_count), 32'd0);
    chk("t3_idle_req", 32'(ext_req), 32'd0);

    // Byte-lane store
    tick();
    store(32'h202, 4'b0010, 32'hABABABAB);
    tick();
    idle_cpu();
    tick();
    chk("t4_we", 32'(ext_we), 32'h2);
    chk("t4_addr", ext_addr, 32'h202);
    chk("t4_wdata", ext_wdata, 32'hABABABAB);
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    #1 chk("t4_cnt0", 32'(wb_count), 32'd0);

    // Load data held across later stores and write acks
    tick();
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h40;
    tick();
    ext_ack = 1'b1;
    ext_rdata = 32'h12345678;
    tick();
    ext_ack = 1'b0;
    ext_rdata = 32'hFFFFFFFF;
    cpu_mem_read_en = 1'b0;
    store(32'h50, 4'hF, 32'h55555550);
    #1 chk("t5_rdata", cpu_mem_read_data, 32'h12345678);
    chk("t5_st_en", 32'(cpu_en), 32'd1);
    tick();
    store(32'h54, 4'hF, 32'h55555554);
    tick();
    store(32'h58, 4'hF, 32'h55555558);
    tick();
    idle_cpu();
    #1 chk("t5_cnt3", 32'(wb_count), 32'd3);
    for (int k = 0; k < 3; k++) begin
      ext_ack = 1'b1;
      tick();
      ext_ack = 1'b0;
      #1 chk("t5_hold", cpu_mem_read_data, 32'h12345678);
    end
    chk("t5_cnt0", 32'(wb_count), 32'd0);

    // Stray ack while idle
    ext_rdata = 32'hBADBAD00;
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    #1 chk("stray_rdata", cpu_mem_read_data, 32'h12345678);
    chk("stray_req", 32'(ext_req), 32'd0);

    // en_in low blocks pushes and read issue
    en_in = 1'b0;
    store(32'h400, 4'hF, 32'h44444444);
    #1 chk("en0_cpuen", 32'(cpu_en), 32'd0);
    tick();
    idle_cpu();
    cpu_mem_read_en = 1'b1;
    #1 chk("en0_cnt", 32'(wb_count), 32'd0);
    tick();
    chk("en0_no_read", 32'(ext_req), 32'd0);
    cpu_mem_read_en = 1'b0;
    en_in = 1'b1;

    // Asynchronous reset in the middle of a read
    tick();
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h80;
    tick();
    chk("t6_in_rd", 32'(ext_req), 32'd1);
    chk("t6_rd_addr", ext_addr, 32'h80);
    #2 rst = 1'b0;
    #1 chk("t6_req_async", 32'(ext_req), 32'd0);
    chk("t6_rdata_async", cpu_mem_read_data, 32'd0);
    chk("t6_cnt_async", 32'(wb_count), 32'd0);
    chk("t6_addr_async", ext_addr, 32'd0);
    cpu_mem_read_en = 1'b0;
    #2 rst = 1'b1;
    tick();
    chk("t6_post_req", 32'(ext_req), 32'd0);
    chk("t6_post_en", 32'(cpu_en), 32'd1);
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h84;
    #1 chk("t6_load_stall", 32'(cpu_en), 32'd0);
    tick();
    chk("t6_idle_to_rd", 32'(ext_req), 32'd1);
    chk("t6_rd_addr2", ext_addr, 32'h84);
    ext_ack = 1'b1;
    ext_rdata = 32'h0F0F0F0F;
    tick();
    ext_ack = 1'b0;
    #1 chk("t6_rdata", cpu_mem_read_data, 32'h0F0F0F0F);
    chk("t6_rdone_en", 32'(cpu_en), 32'd1);
    cpu_mem_read_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", n_chk, 0);
    $fatal(1, "timeout");
  end

endmodule
